// File: rtl/uart_arb_pkg.sv
// Shared constants and FSM state type for the uart_tx packet arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        WAIT  = ST_WAIT
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rotated;
    logic [PTR_W:0]     first_off;
    logic [PTR_W:0]     idx_sum;

    // Doubling the vector lets a plain shift express the wrap-around scan.
    assign req_dbl = {req, req};
    assign rotated = req_dbl[ptr +: N_REQ];

    always_comb begin
        first_off = '0;
        found     = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rotated[j] && !found) begin
                found     = 1'b1;
                first_off = (PTR_W + 1)'(j);
            end
        end
    end

    always_comb begin
        idx_sum = {1'b0, ptr} + first_off;
        if (idx_sum >= (PTR_W + 1)'(N_REQ)) begin
            idx_sum = idx_sum - (PTR_W + 1)'(N_REQ);
        end
        winner_idx = idx_sum[PTR_W-1:0];
        winner     = '0;
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx between N_REQ byte streams,
// with a stall watchdog that drops a packet whose owner stops supplying bytes.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n_clk,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    abort,
    output logic                    uart_tx_send,
    output logic [BYTE_W-1:0]       uart_tx_data,
    input  logic                    uart_tx_done,
    input  logic                    uart_tx_busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e        state, state_d;
    logic [N_REQ-1:0]  grant_d;
    logic [PTR_W-1:0]  gidx, gidx_d;
    logic [PTR_W-1:0]  rr_ptr, rr_ptr_d, next_ptr;
    logic [CNT_W-1:0]  stall_cnt, stall_cnt_d;
    logic              last_q, last_d;
    logic              abort_d, send_d;
    logic [BYTE_W-1:0] data_d, lane_byte;
    logic [N_REQ-1:0]  win_onehot;
    logic [PTR_W-1:0]  win_idx;
    logic              win_valid;
    logic              take;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .found      (win_valid)
    );

    assign lane_byte = req_data[int'(gidx)*BYTE_W +: BYTE_W];
    assign next_ptr  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

    // Only the handshake is combinational so a requester sees its byte taken in-cycle.
    assign req_ready = (state == FETCH && !uart_tx_busy) ? (grant & req_valid) : '0;
    assign take      = |req_ready;

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        gidx_d      = gidx;
        rr_ptr_d    = rr_ptr;
        stall_cnt_d = stall_cnt;
        last_d      = last_q;
        abort_d     = 1'b0;
        send_d      = 1'b0;
        data_d      = uart_tx_data;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_d     = win_onehot;
                    gidx_d      = win_idx;
                    stall_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (take) begin
                    data_d  = lane_byte;
                    send_d  = 1'b1;
                    last_d  = req_last[gidx];
                    state_d = WAIT;
                end else if (stall_cnt == CNT_LAST) begin
                    abort_d     = 1'b1;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    stall_cnt_d = '0;
                    state_d     = IDLE;
                end else if (stall_cnt != CNT_MAX) begin
                    stall_cnt_d = stall_cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                // uart_tx always finishes a frame, so WAIT needs no watchdog.
                if (uart_tx_done) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        stall_cnt_d = '0;
                        state_d     = FETCH;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_clk) begin
        if (!rst_n_clk) begin
            state        <= IDLE;
            grant        <= '0;
            gidx         <= '0;
            rr_ptr       <= '0;
            stall_cnt    <= '0;
            last_q       <= 1'b0;
            abort        <= 1'b0;
            uart_tx_send <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state        <= state_d;
            grant        <= grant_d;
            gidx         <= gidx_d;
            rr_ptr       <= rr_ptr_d;
            stall_cnt    <= stall_cnt_d;
            last_q       <= last_d;
            abort        <= abort_d;
            uart_tx_send <= send_d;
            uart_tx_data <= data_d;
        end
    end

endmodule
